// File: rtl/conv_sched_if.sv
// rtl/conv_sched_if.sv - handshake bundle between conv_sched and the layer datapath
//
// Purpose: groups the layer control, kernel-load, window-fetch and
// pooling-RAM write signals of the convolution sequencer.
// Ports (master = sequencer side):
//   start, abort            layer control in
//   busy, done              layer status out
//   kern_req/kern_ack/kern_idx   kernel load handshake
//   win_req/win_ack/win_row/win_col/sum   window fetch handshake
//   wr_en/wr_addr/wr_data   pooling-RAM write port
interface conv_sched_if #(
  parameter int SUM_W  = 14,
  parameter int ADDR_W = 15
);
  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              kern_req;
  logic              kern_ack;
  logic [5:0]        kern_idx;
  logic              win_req;
  logic              win_ack;
  logic [4:0]        win_row;
  logic [4:0]        win_col;
  logic [SUM_W-1:0]  sum;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;

  modport master (
    input  start, abort, kern_ack, win_ack, sum,
    output busy, done, kern_req, kern_idx, win_req, win_row, win_col,
           wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, abort, kern_ack, win_ack, sum,
    input  busy, done, kern_req, kern_idx, win_req, win_row, win_col,
           wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - kernel/window sequencer for the binary-weight convolution datapath
//
// Purpose: for every kernel, request a kernel load, then fetch each output
// window in row-major order, threshold the accumulated sum against BIAS and
// write the 1-bit result to the pooling RAM at a linear address.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   conv_sched_if.master (control, kernel/window handshakes, RAM write)
module conv_sched #(
  parameter int              OUT_DIM = 24,
  parameter int              N_KERN  = 6,
  parameter int              SUM_W   = 14,
  parameter logic [SUM_W-1:0] BIAS   = 14'h2000,
  parameter int              ADDR_W  = 15
) (
  input  logic         clk,
  input  logic         rst,
  conv_sched_if.master bus
);

  localparam logic [4:0] POS_LAST  = 5'(OUT_DIM - 1);
  localparam logic [5:0] KERN_LAST = 6'(N_KERN - 1);

  typedef enum logic [2:0] {
    IDLE,
    KLOAD,
    WREQ,
    WWAIT,
    WRITE,
    DONE
  } state_t;

  state_t state;

  // wr_addr is kept as a running count rather than a product: positions are
  // visited in exactly linear-address order and the count is cleared with
  // the position counters on start, so it always equals
  // kern_idx*OUT_DIM^2 + win_row*OUT_DIM + win_col during WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.kern_req <= 1'b0;
      bus.kern_idx <= '0;
      bus.win_req  <= 1'b0;
      bus.win_row  <= '0;
      bus.win_col  <= '0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= 1'b0;
    end else if (bus.abort) begin
      // Counters and address are left as-is; the next start clears them.
      state        <= IDLE;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.kern_req <= 1'b0;
      bus.win_req  <= 1'b0;
      bus.wr_en    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= KLOAD;
            bus.busy     <= 1'b1;
            bus.kern_req <= 1'b1;
            bus.kern_idx <= '0;
            bus.win_row  <= '0;
            bus.win_col  <= '0;
            bus.wr_addr  <= '0;
          end
        end
        KLOAD: begin
          if (bus.kern_ack) begin
            state        <= WREQ;
            bus.kern_req <= 1'b0;
            bus.win_req  <= 1'b1;
          end
        end
        WREQ: begin
          state       <= WWAIT;
          bus.win_req <= 1'b0;
        end
        WWAIT: begin
          if (bus.win_ack) begin
            state       <= WRITE;
            bus.wr_en   <= 1'b1;
            bus.wr_data <= (bus.sum >= BIAS);
          end
        end
        WRITE: begin
          bus.wr_en   <= 1'b0;
          bus.wr_addr <= bus.wr_addr + ADDR_W'(1);
          if (bus.win_col < POS_LAST) begin
            bus.win_col <= bus.win_col + 5'd1;
            state       <= WREQ;
            bus.win_req <= 1'b1;
          end else begin
            bus.win_col <= '0;
            if (bus.win_row < POS_LAST) begin
              bus.win_row <= bus.win_row + 5'd1;
              state       <= WREQ;
              bus.win_req <= 1'b1;
            end else begin
              bus.win_row <= '0;
              if (bus.kern_idx < KERN_LAST) begin
                bus.kern_idx <= bus.kern_idx + 6'd1;
                state        <= KLOAD;
                bus.kern_req <= 1'b1;
              end else begin
                state    <= DONE;
                bus.done <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
